// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: registered valid/ready, one-cycle latency, full throughput.
// Optional stall counter on stall_cnt when PIPE_STAT_EN is defined.
module pipe_skid_reg #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef PIPE_STAT_EN
    output logic [CW-1:0] stall_cnt,
`endif
    output logic [DW-1:0] out_data
);

    if (DW < 1 || DW > 256 || CW < 1) begin : g_param_check
        $error("pipe_skid_reg: DW must be 1..256 and CW at least 1");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          in_ready_q, out_valid_q;
    logic          in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state and data steering; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake flags are flops loaded from the next state, so they never see out_ready/in_valid combinationally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_STAT_EN
    logic [CW-1:0] stall_q, stall_d;

    // Saturating count of cycles the downstream refuses a valid payload; flush leaves it alone.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && (stall_q != {CW{1'b1}})) begin
            stall_d = stall_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random traffic against a queue model.
// Define PIPE_STAT_EN to also exercise the stall counter (built with CW=4).
module tb_pipe_skid_reg;

    localparam int unsigned DW = 32;
`ifdef PIPE_STAT_EN
    localparam int unsigned CW = 4;
`else
    localparam int unsigned CW = 16;
`endif

    logic          CLK = 1'b0;
    logic          RST, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q[$];
    int            model_stall = 0;
    int            stall_max   = (1 << CW) - 1;

    always #5 CLK = ~CLK;

    pipe_skid_reg #(.DW(DW), .CW(CW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef PIPE_STAT_EN
        .stall_cnt(stall_cnt),
`endif
        .out_data (out_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a falling edge: checks outputs against the model, drives one cycle, advances the model.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [DW-1:0] d, input logic ordy);
        int  sz;
        logic ofire, ifire;
        sz = model_q.size();
        check("out_valid", 64'(out_valid), 64'(sz > 0));
        check("in_ready", 64'(in_ready), 64'(sz < 2));
        if (sz > 0) check("out_data", 64'(out_data), 64'(model_q[0]));
`ifdef PIPE_STAT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(model_stall));
`endif
        RST = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge CLK);
        ofire = (sz > 0) && ordy;
        ifire = iv && (sz < 2);
        if (r) begin
            model_q.delete();
            model_stall = 0;
        end else begin
            if (sz > 0 && !ordy && model_stall < stall_max) model_stall++;
            if (ofire) void'(model_q.pop_front());
            if (f) model_q.delete();
            else if (ifire) model_q.push_back(d);
        end
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
`ifdef PIPE_STAT_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        model_q.delete();

        // Streaming 1,2,3 with downstream always ready
        step(0, 0, 1, 32'h1, 1);
        check("stream_d1", 64'(out_data), 64'h1);
        step(0, 0, 1, 32'h2, 1);
        check("stream_d2", 64'(out_data), 64'h2);
        step(0, 0, 1, 32'h3, 1);
        check("stream_d3", 64'(out_data), 64'h3);
        check("stream_rdy", 64'(in_ready), 64'd1);
        step(0, 0, 0, 32'h0, 1);
        check("stream_drain", 64'(out_valid), 64'd0);

        // Backpressure: A then B fill both entries
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 1, 32'hB, 0);
        check("bp_full_rdy", 64'(in_ready), 64'd0);
        check("bp_hold_a", 64'(out_data), 64'hA);
        step(0, 0, 1, 32'hF, 0);
        check("bp_still_a", 64'(out_data), 64'hA);
        step(0, 0, 0, 32'h0, 1);
        check("bp_then_b", 64'(out_data), 64'hB);
        check("bp_rdy_back", 64'(in_ready), 64'd1);
        step(0, 0, 0, 32'h0, 1);
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush while FULL with a pending 0xC
        step(0, 0, 1, 32'h11, 0);
        step(0, 0, 1, 32'h22, 0);
        step(0, 1, 1, 32'hC, 0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_rdy", 64'(in_ready), 64'd1);
        step(0, 0, 0, 32'h0, 1);
        check("flush_no_c", 64'(out_valid), 64'd0);

        // Simultaneous in/out fire while one entry held
        step(0, 0, 1, 32'h31, 0);
        step(0, 0, 1, 32'h32, 1);
        check("sim_data", 64'(out_data), 64'h32);
        check("sim_rdy", 64'(in_ready), 64'd1);
        step(0, 0, 0, 32'h0, 1);

`ifdef PIPE_STAT_EN
        // Saturation of the 4-bit stall counter, then flush must not clear it
        step(0, 0, 1, 32'h55, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, 0);
        check("stall_sat", 64'(stall_cnt), 64'd15);
        step(0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        check("stall_flush", 64'(stall_cnt), 64'd15);
        step(1, 0, 0, 32'h0, 0);
        check("stall_rst", 64'(stall_cnt), 64'd0);
`endif

        // Random traffic, including rare flushes and mid-transfer resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0), $urandom(),
                 ($urandom_range(0, 2) != 0));
        end

        step(1, 0, 0, 32'h0, 0);
        check("end_rst_data", 64'(out_data), 64'd0);
        check("end_rst_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule
